// File: rtl/pipe_hazard_if.sv
// Signal bundle between the pipeline datapath and the hazard/stall sequencer.
// The datapath is the master: it reports ID/EXE/MEM status and receives the stall/flush controls.
interface pipe_hazard_if #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
);
  logic             fwd_en;
  logic             id_valid;
  logic [REG_W-1:0] id_src1;
  logic [REG_W-1:0] id_src2;
  logic             id_two_src;
  logic [REG_W-1:0] exe_dest;
  logic             exe_wb_en;
  logic             exe_mem_read;
  logic [REG_W-1:0] mem_dest;
  logic             mem_wb_en;
  logic             branch_taken;
  logic             mem_busy;
  logic             pc_freeze;
  logic             ifid_freeze;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             freeze_all;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [1:0]       state;

  modport master (
    output fwd_en, id_valid, id_src1, id_src2, id_two_src, exe_dest, exe_wb_en,
           exe_mem_read, mem_dest, mem_wb_en, branch_taken, mem_busy,
    input  pc_freeze, ifid_freeze, ifid_flush, idex_bubble, freeze_all,
           mem_timeout, stall_cycles, state
  );

  modport slave (
    input  fwd_en, id_valid, id_src1, id_src2, id_two_src, exe_dest, exe_wb_en,
           exe_mem_read, mem_dest, mem_wb_en, branch_taken, mem_busy,
    output pc_freeze, ifid_freeze, ifid_flush, idex_bubble, freeze_all,
           mem_timeout, stall_cycles, state
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// IF/ID + PC sequencer: RAW hazard stalls, multi-cycle branch flush, data-memory wait freeze,
// wait watchdog and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int REG_W        = 4,
  parameter int FLUSH_CYCLES = 1,
  parameter int MAX_WAIT     = 255,
  parameter int CNT_W        = 16
) (
  input  logic          clk,
  input  logic          rst,
  pipe_hazard_if.slave  bus
);
  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int WC_W = $clog2(MAX_WAIT + 1);
  localparam logic [FC_W-1:0] FLUSH_RELOAD = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [WC_W-1:0] WAIT_MAX     = WC_W'(MAX_WAIT);
  localparam logic [WC_W-1:0] WAIT_LAST    = WC_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  state_t          state_q, state_n;
  logic [FC_W-1:0] flush_cnt_q, flush_cnt_n, flush_dec;
  logic [WC_W-1:0] wait_cnt_q;
  logic            timeout_q;
  logic [CNT_W-1:0] stall_q;

  logic m_src1, m_src2, hazard;
  logic pc_freeze_c, ifid_freeze_c, ifid_flush_c, idex_bubble_c, freeze_all_c;

  // With forwarding only a load in EXE can't be bypassed; without it any pending write stalls.
  assign m_src1 = (bus.exe_wb_en && bus.exe_dest == bus.id_src1 && (!bus.fwd_en || bus.exe_mem_read))
                || (!bus.fwd_en && bus.mem_wb_en && bus.mem_dest == bus.id_src1);
  assign m_src2 = (bus.exe_wb_en && bus.exe_dest == bus.id_src2 && (!bus.fwd_en || bus.exe_mem_read))
                || (!bus.fwd_en && bus.mem_wb_en && bus.mem_dest == bus.id_src2);
  assign hazard = bus.id_valid && (m_src1 || (bus.id_two_src && m_src2));

  assign flush_dec = flush_cnt_q - 1'b1;

  always_comb begin
    // NOTE: every variable gets a default here first, so no path can infer a latch.
    state_n       = state_q;
    flush_cnt_n   = flush_cnt_q;
    pc_freeze_c   = 1'b0;
    ifid_freeze_c = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_bubble_c = 1'b0;
    freeze_all_c  = 1'b0;
    if (bus.mem_busy) begin
      // A pending flush keeps its state and count and resumes once memory is ready.
      freeze_all_c = 1'b1;
      if (state_q == ST_RUN) state_n = ST_MEM_WAIT;
    end else if (bus.branch_taken) begin
      ifid_flush_c  = 1'b1;
      idex_bubble_c = 1'b1;
      flush_cnt_n   = FLUSH_RELOAD;
      state_n       = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
    end else if (state_q == ST_FLUSH) begin
      ifid_flush_c  = 1'b1;
      idex_bubble_c = 1'b1;
      if (flush_cnt_q <= 1) begin
        flush_cnt_n = '0;
        state_n     = ST_RUN;
      end else begin
        flush_cnt_n = flush_dec;
      end
    end else begin
      // RUN, or the first ready cycle leaving MEM_WAIT.
      state_n = ST_RUN;
      if (hazard) begin
        pc_freeze_c   = 1'b1;
        ifid_freeze_c = 1'b1;
        idex_bubble_c = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_n;
      flush_cnt_q <= flush_cnt_n;
      if (!bus.mem_busy)              wait_cnt_q <= '0;
      else if (wait_cnt_q != WAIT_MAX) wait_cnt_q <= wait_cnt_q + 1'b1;
      if (bus.mem_busy && wait_cnt_q == WAIT_LAST) timeout_q <= 1'b1;
      if ((pc_freeze_c || freeze_all_c) && stall_q != '1) stall_q <= stall_q + 1'b1;
    end
  end

  // Every output reads zero while reset is held, including the registered ones.
  assign bus.pc_freeze    = pc_freeze_c   && !rst;
  assign bus.ifid_freeze  = ifid_freeze_c && !rst;
  assign bus.ifid_flush   = ifid_flush_c  && !rst;
  assign bus.idex_bubble  = idex_bubble_c && !rst;
  assign bus.freeze_all   = freeze_all_c  && !rst;
  assign bus.mem_timeout  = timeout_q     && !rst;
  assign bus.stall_cycles = rst ? '0 : stall_q;
  assign bus.state        = rst ? 2'd0 : state_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with FLUSH_CYCLES=3, MAX_WAIT=5.
// Inputs change 1 ns after posedge; outputs are sampled on the falling edge.
module tb_pipe_hazard_ctrl;
  localparam logic [4:0] C_NONE  = 5'b00000;
  localparam logic [4:0] C_STALL = 5'b11010;  // {pc_freeze, ifid_freeze, ifid_flush, idex_bubble, freeze_all}
  localparam logic [4:0] C_FLUSH = 5'b00110;
  localparam logic [4:0] C_FRZ   = 5'b00001;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  pipe_hazard_if #(.REG_W(4), .CNT_W(16)) bus ();

  pipe_hazard_ctrl #(.REG_W(4), .FLUSH_CYCLES(3), .MAX_WAIT(5), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] ctl();
    return {bus.pc_freeze, bus.ifid_freeze, bus.ifid_flush, bus.idex_bubble, bus.freeze_all};
  endfunction

  task automatic clear_inputs();
    bus.fwd_en = 0; bus.id_valid = 0; bus.id_src1 = 0; bus.id_src2 = 0; bus.id_two_src = 0;
    bus.exe_dest = 0; bus.exe_wb_en = 0; bus.exe_mem_read = 0; bus.mem_dest = 0;
    bus.mem_wb_en = 0; bus.branch_taken = 0; bus.mem_busy = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Sample the current cycle, compare controls and state, then advance one clock.
  task automatic expect_cycle(input string tag, input logic [4:0] exp_ctl, input logic [1:0] exp_st);
    @(negedge clk);
    check({tag, "_ctl"}, 32'(ctl()), 32'(exp_ctl));
    check({tag, "_st"}, 32'(bus.state), 32'(exp_st));
    next_cycle();
  endtask

  task automatic expect_stall_cnt(input string tag, input int exp);
    @(negedge clk);
    check(tag, 32'(bus.stall_cycles), exp);
  endtask

  // ID reads r3 (src1), EXE writes r3.
  task automatic set_exe_raw();
    clear_inputs();
    bus.id_valid = 1; bus.id_src1 = 4'd3; bus.exe_dest = 4'd3; bus.exe_wb_en = 1;
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    bus.mem_busy = 1; bus.branch_taken = 1;
    next_cycle();
    @(negedge clk);
    check("rst_ctl", 32'(ctl()), 32'(C_NONE));
    check("rst_state", 32'(bus.state), 0);
    check("rst_timeout", 32'(bus.mem_timeout), 0);
    check("rst_stall", 32'(bus.stall_cycles), 0);
    next_cycle();
    rst = 0;
    clear_inputs();
    expect_cycle("idle", C_NONE, 2'd0);

    // Plain RAW stalls without forwarding; register 0 is not special.
    set_exe_raw();                                       expect_cycle("raw_exe", C_STALL, 2'd0);
    clear_inputs();                                      expect_stall_cnt("stall_after_raw", 1);
    set_exe_raw(); bus.id_valid = 0;                     expect_cycle("raw_invalid", C_NONE, 2'd0);
    set_exe_raw(); bus.id_src1 = 4'd1; bus.id_src2 = 4'd3;
                                                         expect_cycle("src2_unused", C_NONE, 2'd0);
    set_exe_raw(); bus.id_src1 = 4'd1; bus.id_src2 = 4'd3; bus.id_two_src = 1;
                                                         expect_cycle("src2_used", C_STALL, 2'd0);
    set_exe_raw(); bus.exe_wb_en = 0; bus.mem_wb_en = 1; bus.mem_dest = 4'd3;
                                                         expect_cycle("raw_mem_nofwd", C_STALL, 2'd0);
    set_exe_raw(); bus.id_src1 = 4'd0; bus.exe_dest = 4'd0;
                                                         expect_cycle("raw_r0", C_STALL, 2'd0);

    // Forwarding: only load-use stalls.
    set_exe_raw(); bus.fwd_en = 1;                       expect_cycle("fwd_alu", C_NONE, 2'd0);
    set_exe_raw(); bus.fwd_en = 1; bus.exe_mem_read = 1; expect_cycle("fwd_load", C_STALL, 2'd0);
    set_exe_raw(); bus.fwd_en = 1; bus.exe_wb_en = 0; bus.mem_wb_en = 1; bus.mem_dest = 4'd3;
                                                         expect_cycle("fwd_mem", C_NONE, 2'd0);
    clear_inputs();                                      expect_stall_cnt("stall_after_fwd", 5);
    next_cycle();

    // Three-cycle branch flush.
    clear_inputs(); bus.branch_taken = 1;                expect_cycle("br_t0", C_FLUSH, 2'd0);
    clear_inputs();                                      expect_cycle("br_t1", C_FLUSH, 2'd1);
                                                         expect_cycle("br_t2", C_FLUSH, 2'd1);
                                                         expect_cycle("br_t3", C_NONE, 2'd0);

    // Branch beats hazard; hazard inside FLUSH ignored, then stalls in RUN.
    set_exe_raw(); bus.branch_taken = 1;                 expect_cycle("brhz_t0", C_FLUSH, 2'd0);
    set_exe_raw();                                       expect_cycle("brhz_t1", C_FLUSH, 2'd1);
                                                         expect_cycle("brhz_t2", C_FLUSH, 2'd1);
                                                         expect_cycle("brhz_t3", C_STALL, 2'd0);
    clear_inputs();                                      expect_stall_cnt("stall_after_brhz", 6);
    next_cycle();

    // Branch inside FLUSH reloads the count.
    bus.branch_taken = 1;                                expect_cycle("rel_t0", C_FLUSH, 2'd0);
    clear_inputs();                                      expect_cycle("rel_t1", C_FLUSH, 2'd1);
    bus.branch_taken = 1;                                expect_cycle("rel_t2", C_FLUSH, 2'd1);
    clear_inputs();                                      expect_cycle("rel_t3", C_FLUSH, 2'd1);
                                                         expect_cycle("rel_t4", C_FLUSH, 2'd1);
                                                         expect_cycle("rel_t5", C_NONE, 2'd0);

    // mem_busy pauses a flush for 4 cycles; the flush then finishes.
    bus.branch_taken = 1;                                expect_cycle("fb_t0", C_FLUSH, 2'd0);
    clear_inputs();                                      expect_cycle("fb_t1", C_FLUSH, 2'd1);
    bus.mem_busy = 1;
    for (int i = 0; i < 4; i++)                          expect_cycle($sformatf("fb_busy%0d", i), C_FRZ, 2'd1);
    bus.mem_busy = 0;                                    expect_cycle("fb_resume", C_FLUSH, 2'd1);
                                                         expect_cycle("fb_done", C_NONE, 2'd0);
    @(negedge clk);
    check("fb_timeout", 32'(bus.mem_timeout), 0);
    check("fb_stall", 32'(bus.stall_cycles), 10);
    next_cycle();

    // Watchdog: reset, then 7 busy cycles with MAX_WAIT=5.
    rst = 1;                                             next_cycle();
    rst = 0;
    clear_inputs(); bus.mem_busy = 1;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      check($sformatf("wd_ctl%0d", i), 32'(ctl()), 32'(C_FRZ));
      check($sformatf("wd_st%0d", i), 32'(bus.state), (i == 1) ? 0 : 2);
      if (i == 4) check("wd_timeout_early", 32'(bus.mem_timeout), 0);
      if (i == 6) check("wd_timeout_set", 32'(bus.mem_timeout), 1);
      next_cycle();
    end
    // Exit cycle from MEM_WAIT decodes like RUN: a hazard stalls.
    set_exe_raw();
    @(negedge clk);
    check("wd_stall7", 32'(bus.stall_cycles), 7);
    check("wd_timeout_sticky", 32'(bus.mem_timeout), 1);
    check("wd_exit_ctl", 32'(ctl()), 32'(C_STALL));
    check("wd_exit_st", 32'(bus.state), 2);
    next_cycle();
    clear_inputs();                                      expect_cycle("wd_run", C_NONE, 2'd0);
    check("wd_stall8", 32'(bus.stall_cycles), 8);

    // Reset from MEM_WAIT aborts to RUN and clears the sticky timeout.
    bus.mem_busy = 1;                                    expect_cycle("mw_enter", C_FRZ, 2'd0);
    expect_cycle("mw_wait", C_FRZ, 2'd2);
    rst = 1;
    @(negedge clk);
    check("mw_rst_ctl", 32'(ctl()), 32'(C_NONE));
    check("mw_rst_st", 32'(bus.state), 0);
    next_cycle();
    rst = 0; clear_inputs();
    @(negedge clk);
    check("post_rst_st", 32'(bus.state), 0);
    check("post_rst_timeout", 32'(bus.mem_timeout), 0);
    check("post_rst_stall", 32'(bus.stall_cycles), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
